// File: rtl/simd_array_pkg.sv
// rtl/simd_array_pkg.sv - shared types and helpers for the SIMD lane array
//
// Purpose: operation and FSM state encodings, plus the most-negative
// accumulator value used to seed MAX reductions.
package simd_array_pkg;

  typedef enum logic [1:0] {
    OP_MAC  = 2'b00,
    OP_SUM  = 2'b01,
    OP_MAX  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_FLUSH = 2'b10,
    S_DRAIN = 2'b11
  } state_e;

  // Most-negative two's complement value of width w, returned
  // zero-extended in a 128-bit container (callers slice to their width).
  function automatic logic [127:0] acc_min(input int w);
    logic [127:0] v;
    v        = '0;
    v[w-1]   = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/simd_lane.sv
// rtl/simd_lane.sv - one lane: registered term stage followed by accumulate stage
//
// Purpose: stage 1 registers the per-pair term (a*b or a+b), stage 2 folds
// it into the accumulator (wrapping add, or signed max).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clr        start of a command: empty the pipe and seed the accumulator
//   clr_max    seed with the most-negative value instead of zero
//   we         operand pair for this lane is valid this cycle
//   op         latched operation of the running command
//   a, b       signed operands
//   acc        current accumulator value
module simd_lane
  import simd_array_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     clr_max,
  input  logic                     we,
  input  op_e                      op,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic        [ACC_W-1:0]  acc
);

  // Wide enough for the exact product and sum, and never narrower than acc.
  localparam int WW = (2*DATA_W > ACC_W) ? 2*DATA_W : ACC_W;
  localparam logic [127:0]     ACC_MIN_WIDE = acc_min(ACC_W);
  localparam logic [ACC_W-1:0] ACC_MIN_V    = ACC_MIN_WIDE[ACC_W-1:0];

  logic signed [WW-1:0]    a_w, b_w, prod_w, sum_w;
  logic        [ACC_W-1:0] term, term_q, acc_q;
  logic                    term_v_q;

  always_comb begin
    a_w    = WW'(a);
    b_w    = WW'(b);
    prod_w = a_w * b_w;
    sum_w  = a_w + b_w;
    term   = (op == OP_SUM) ? ACC_W'(sum_w) : ACC_W'(prod_w);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      term_q   <= '0;
      term_v_q <= 1'b0;
      acc_q    <= '0;
    end else if (clr) begin
      term_q   <= '0;
      term_v_q <= 1'b0;
      acc_q    <= clr_max ? ACC_MIN_V : '0;
    end else begin
      term_v_q <= we;
      if (we) term_q <= term;
      if (term_v_q) begin
        if (op == OP_MAX) begin
          if ($signed(term_q) > $signed(acc_q)) acc_q <= term_q;
        end else begin
          acc_q <= acc_q + term_q;
        end
      end
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/simd_lane_array.sv
// rtl/simd_lane_array.sv - NUM_LANES-wide reduction array with command, operand and result ports
//
// Purpose: accepts a command (op, K), distributes K*NUM_LANES operand pairs
// round-robin over the lanes, then drains one lane result per beat.
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   cmd_valid/ready, op, len     command handshake (ready only in IDLE)
//   in_valid/ready, in_a, in_b   operand pair stream (ready only in LOAD)
//   out_valid/ready, data, lane  result stream, lanes in ascending order
//   busy                         not idle
//   done                         pulse after the last result is taken
//   err                          pulse on a rejected command
module simd_lane_array
  import simd_array_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 32,
  parameter int ACC_W     = 32,
  parameter int K_MAX     = 16,
  parameter int LEN_W     = $clog2(K_MAX+1),
  parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [LEN_W-1:0]         cmd_len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_data,
  output logic [LANE_W-1:0]        out_lane,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES-1);

  state_e            state, state_n;
  op_e               op_q;
  logic [LEN_W-1:0]  len_q, row_cnt;
  logic [LANE_W-1:0] lane_cnt, drain_idx;
  logic              cmd_fire, cmd_bad, cmd_ok, in_fire, last_beat, out_fire, last_out;
  logic [ACC_W-1:0]  acc_arr [NUM_LANES];

  assign cmd_ready = (state == S_IDLE);
  assign in_ready  = (state == S_LOAD);
  assign out_valid = (state == S_DRAIN);
  assign busy      = (state != S_IDLE);

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign cmd_bad   = (cmd_len == '0) || (cmd_len > LEN_W'(K_MAX)) || (cmd_op == 2'b11);
  assign cmd_ok    = cmd_fire && !cmd_bad;
  assign in_fire   = in_valid && in_ready;
  // Last beat: final lane of the final row.
  assign last_beat = in_fire && (lane_cnt == LAST_LANE) && (row_cnt == len_q - 1'b1);
  assign out_fire  = out_valid && out_ready;
  assign last_out  = out_fire && (drain_idx == LAST_LANE);

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (cmd_ok)    state_n = S_LOAD;
      S_LOAD:  if (last_beat) state_n = S_FLUSH;
      S_FLUSH:                state_n = S_DRAIN;  // final term lands in acc
      S_DRAIN: if (last_out)  state_n = S_IDLE;
      default:                state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q      <= OP_MAC;
      len_q     <= '0;
      row_cnt   <= '0;
      lane_cnt  <= '0;
      drain_idx <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= last_out;
      err  <= cmd_fire && cmd_bad;
      if (cmd_ok) begin
        op_q      <= op_e'(cmd_op);
        len_q     <= cmd_len;
        row_cnt   <= '0;
        lane_cnt  <= '0;
        drain_idx <= '0;
      end
      if (in_fire) begin
        if (lane_cnt == LAST_LANE) begin
          lane_cnt <= '0;
          row_cnt  <= row_cnt + 1'b1;
        end else begin
          lane_cnt <= lane_cnt + 1'b1;
        end
      end
      if (out_fire) drain_idx <= (drain_idx == LAST_LANE) ? '0 : drain_idx + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    simd_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk     (CLK),
      .rst     (RST),
      .clr     (cmd_ok),
      .clr_max (cmd_op == 2'b10),
      .we      (in_fire && (lane_cnt == LANE_W'(i))),
      .op      (op_q),
      .a       (in_a),
      .b       (in_b),
      .acc     (acc_arr[i])
    );
  end

  assign out_data = acc_arr[drain_idx];
  assign out_lane = drain_idx;

endmodule

// File: tb/tb_simd_lane_array.sv
// tb/tb_simd_lane_array.sv - scoreboard bench for simd_lane_array
module tb_simd_lane_array;

  logic        CLK, RST;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_len;
  logic        in_valid, in_ready;
  logic signed [31:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_lane;
  logic        busy, done, err;

  typedef struct packed {
    logic [1:0]  lane;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   stall_en = 0;
  bit   rand_bubble = 0;

  simd_lane_array dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_lane(out_lane),
    .busy(busy), .done(done), .err(err)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [1:0] lane, input logic [31:0] data);
    exp_t e;
    e.lane = lane;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [4:0] len);
    int n = 0;
    cmd_op = op;
    cmd_len = len;
    cmd_valid = 1;
    while (!cmd_ready && n < 200) begin tick(); n++; end
    if (n >= 200) chk("cmd_ready_timeout", 0, 1);
    tick();
    cmd_valid = 0;
  endtask

  task automatic send_pair(input logic signed [31:0] a, input logic signed [31:0] b);
    int n = 0;
    if (rand_bubble) begin
      in_valid = 0;
      repeat ($urandom_range(0, 2)) tick();
    end
    in_a = a;
    in_b = b;
    in_valid = 1;
    while (!in_ready && n < 200) begin tick(); n++; end
    if (n >= 200) chk("in_ready_timeout", 0, 1);
    tick();
    in_valid = 0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin tick(); n++; end
    if (n >= 500) chk("drain_timeout", sb.size(), 0);
    chk("done_pulse", done, 1);
    chk("cmd_ready_after_done", cmd_ready, 1);
    chk("busy_after_done", busy, 0);
    tick();
    chk("done_one_cycle", done, 0);
  endtask

  task automatic rejected_cmd(input string name, input logic [1:0] op, input logic [4:0] len);
    send_cmd(op, len);
    chk({name, "_err"}, err, 1);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_out_valid"}, out_valid, 0);
    tick();
    chk({name, "_err_clear"}, err, 0);
    chk({name, "_still_idle"}, cmd_ready, 1);
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (stall_en) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops the scoreboard on every accepted result and checks that
  // a stalled result holds still until it is taken.
  initial begin
    bit          hold;
    logic [31:0] hold_data;
    logic [1:0]  hold_lane;
    exp_t        e;
    hold = 0;
    hold_data = '0;
    hold_lane = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        hold = 0;
      end else begin
        if (out_valid) begin
          if (hold) begin
            chk("hold_data", out_data, hold_data);
            chk("hold_lane", out_lane, hold_lane);
          end
          if (out_ready) begin
            if (sb.size() == 0) begin
              chk("unexpected_output", out_valid, 0);
            end else begin
              e = sb.pop_front();
              chk("out_data", out_data, e.data);
              chk("out_lane", out_lane, e.lane);
            end
          end
        end
        hold = out_valid && !out_ready;
        hold_data = out_data;
        hold_lane = out_lane;
      end
    end
  end

  initial begin
    RST = 1;
    cmd_valid = 0; cmd_op = 0; cmd_len = 0;
    in_valid = 0; in_a = 0; in_b = 0;
    out_ready = 1;
    repeat (3) tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_lane", out_lane, 0);
    RST = 0;
    tick();

    // MAC K=2: lane i gets pairs i+1 and i+5 squared.
    push(0, 26); push(1, 40); push(2, 58); push(3, 80);
    send_cmd(2'b00, 2);
    chk("mac_busy", busy, 1);
    for (int i = 1; i <= 8; i++) send_pair(i, i);
    chk("flush_no_valid", out_valid, 0);
    tick();
    chk("first_valid_latency", out_valid, 1);
    wait_drain();

    // MAX K=3: lane0 products -5,-2,-9; other lanes all zero.
    push(0, 32'hFFFF_FFFE); push(1, 0); push(2, 0); push(3, 0);
    send_cmd(2'b10, 3);
    send_pair(-5, 1); send_pair(0, 0); send_pair(0, 0); send_pair(0, 0);
    send_pair(-2, 1); send_pair(0, 0); send_pair(0, 0); send_pair(0, 0);
    send_pair(3, -3); send_pair(0, 0); send_pair(0, 0); send_pair(0, 0);
    wait_drain();

    // SUM K=1 with wrap in lane0.
    push(0, 32'h8000_0000); push(1, 32'hFFFF_FFFE); push(2, 11); push(3, 0);
    send_cmd(2'b01, 1);
    send_pair(32'sh7FFF_FFFF, 1); send_pair(-3, 1); send_pair(5, 6); send_pair(0, 0);
    wait_drain();

    rejected_cmd("len0", 2'b00, 0);
    rejected_cmd("len17", 2'b00, 17);
    rejected_cmd("op11", 2'b11, 2);

    // MAC K=2 again with input bubbles and output stalls.
    rand_bubble = 1;
    stall_en = 1;
    push(0, 26); push(1, 40); push(2, 58); push(3, 80);
    send_cmd(2'b00, 2);
    for (int i = 1; i <= 8; i++) send_pair(i, i);
    begin
      int n = 0;
      while (sb.size() != 0 && n < 500) begin tick(); n++; end
      if (n >= 500) chk("stall_drain_timeout", sb.size(), 0);
    end
    stall_en = 0;
    rand_bubble = 0;
    out_ready = 1;
    repeat (2) tick();
    chk("stall_back_idle", cmd_ready, 1);

    // Reset in the middle of LOAD, then a fresh K=1 MAC.
    send_cmd(2'b00, 2);
    send_pair(9, 9); send_pair(9, 9); send_pair(9, 9);
    RST = 1;
    tick();
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    RST = 0;
    tick();
    push(0, 2); push(1, 12); push(2, 30); push(3, 56);
    send_cmd(2'b00, 1);
    send_pair(1, 2); send_pair(3, 4); send_pair(5, 6); send_pair(7, 8);
    wait_drain();

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
